// File: rtl/gate_sweep_checker.sv
// Self-test stage for the basic two-input gate set. It drives the shared
// gate inputs a,b through all four input vectors. For each vector it checks the
// seven gate outputs against their truth tables. It accumulates per-gate
// sticky fail flags and a saturating mismatch count.
//
// state  | meaning
// IDLE   | a=b=0, waiting for start
// SETTLE | current vector held on a,b while the gates settle
// CHECK  | one cycle: compare gate outputs, advance vector/pass
// DONE   | one cycle: publish done pulse and pass result
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             and_c,
    input  logic             or_c,
    input  logic             not_b,
    input  logic             nand_c,
    input  logic             nor_c,
    input  logic             xor_c,
    input  logic             xnor_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       fail_vec,
    output logic [ERR_W-1:0] err_count
);

    localparam int SCW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW   = (PASSES > 1) ? $clog2(PASSES) : 1;
    // Sum width covers both the count and a full 7-mismatch add
    localparam int SUMW = ((ERR_W > 3) ? ERR_W : 3) + 1;
    localparam logic [SUMW-1:0] ERR_MAX = {{(SUMW-ERR_W){1'b0}}, {ERR_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [PW-1:0]    pidx_q, pidx_d;
    logic [SCW-1:0]   scnt_q, scnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [6:0]       fail_vec_q, fail_vec_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [6:0]       exp_out;
    logic [6:0]       obs_out;
    logic [6:0]       miss;
    logic [2:0]       miss_cnt;
    logic [SUMW-1:0]  err_sum;

    // Expected gate outputs for the vector currently on a,b; not gate follows a only
    always_comb begin
        exp_out = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q),
                   ~a_q, a_q | b_q, a_q & b_q};
        obs_out = {xnor_c, xor_c, nor_c, nand_c, not_b, or_c, and_c};
        miss    = exp_out ^ obs_out;
        miss_cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            miss_cnt = miss_cnt + {2'b00, miss[i]};
        end
        err_sum = SUMW'(err_q) + SUMW'(miss_cnt);
    end

    // Next-state and registered-output logic for the sweep sequencer
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        pidx_d     = pidx_q;
        scnt_d     = scnt_q;
        a_d        = a_q;
        b_d        = b_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_vec_d = fail_vec_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    err_d      = '0;
                    fail_vec_d = '0;
                    pass_d     = 1'b0;
                    vec_d      = 2'd0;
                    pidx_d     = '0;
                    scnt_d     = '0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (scnt_q == SCW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    scnt_d = scnt_q + SCW'(1);
                end
            end
            ST_CHECK: begin
                fail_vec_d = fail_vec_q | miss;
                err_d      = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
                scnt_d     = '0;
                if (vec_q != 2'd3) begin
                    vec_d      = vec_q + 2'd1;
                    {a_d, b_d} = vec_q + 2'd1;
                    state_d    = ST_SETTLE;
                end else if (pidx_q != PW'(PASSES - 1)) begin
                    vec_d      = 2'd0;
                    {a_d, b_d} = 2'b00;
                    pidx_d     = pidx_q + PW'(1);
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vec_q      <= 2'd0;
            pidx_q     <= '0;
            scnt_q     <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            pidx_q     <= pidx_d;
            scnt_q     <= scnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_vec_q <= fail_vec_d;
            err_q      <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker. There are three instances: u0 uses the defaults,
// u1 has PASSES=2 and u2 has ERR_W=2. Each instance has its own gate model.
// Some models carry a planted gate fault. Expected sweep results are queued
// when start is issued and checked when done is seen.
module tb_gate_sweep_checker;

    typedef struct {
        logic       pass;
        int         err;
        logic [6:0] fv;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int   mode0 = 0;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic a0, b0, busy0, done0, pass0;
    logic a1, b1, busy1, done1, pass1;
    logic a2, b2, busy2, done2, pass2;
    logic [6:0] fv0, fv1, fv2;
    logic [5:0] err0, err1;
    logic [1:0] err2;
    logic and0, or0, not0, nand0, nor0, xor0, xnor0;
    logic and1, or1, not1, nand1, nor1, xor1, xnor1;
    logic and2, or2, not2, nand2, nor2, xor2, xnor2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: correct gates, or xor output stuck at 0 when mode0==1
    always_comb begin
        and0 = a0 & b0;  or0 = a0 | b0;  not0 = ~a0;
        nand0 = ~(a0 & b0); nor0 = ~(a0 | b0);
        xor0 = (mode0 == 1) ? 1'b0 : (a0 ^ b0);
        xnor0 = ~(a0 ^ b0);
    end
    // u1: and output wired from a nand gate
    always_comb begin
        and1 = ~(a1 & b1); or1 = a1 | b1; not1 = ~a1;
        nand1 = ~(a1 & b1); nor1 = ~(a1 | b1);
        xor1 = a1 ^ b1; xnor1 = ~(a1 ^ b1);
    end
    // u2: every output inverted
    always_comb begin
        and2 = ~(a2 & b2); or2 = ~(a2 | b2); not2 = a2;
        nand2 = a2 & b2; nor2 = a2 | b2;
        xor2 = ~(a2 ^ b2); xnor2 = a2 ^ b2;
    end

    gate_sweep_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
        .and_c(and0), .or_c(or0), .not_b(not0), .nand_c(nand0), .nor_c(nor0),
        .xor_c(xor0), .xnor_c(xnor0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0), .err_count(err0));

    gate_sweep_checker #(.PASSES(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .and_c(and1), .or_c(or1), .not_b(not1), .nand_c(nand1), .nor_c(nor1),
        .xor_c(xor1), .xnor_c(xnor1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .err_count(err1));

    gate_sweep_checker #(.ERR_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .and_c(and2), .or_c(or2), .not_b(not2), .nand_c(nand2), .nor_c(nor2),
        .xor_c(xor2), .xnor_c(xnor2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_vec(fv2), .err_count(err2));

    task automatic cmp(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int idx, input logic d, input logic p, input int err,
                       input logic [6:0] fv);
        exp_t e;
        int   sz;
        if (d) begin
            sz = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
            if (sz == 0) begin
                cmp($sformatf("u%0d unexpected done", idx), 1, 0);
            end else begin
                case (idx)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                cmp($sformatf("u%0d pass", idx), int'(p), int'(e.pass));
                cmp($sformatf("u%0d err_count", idx), err, e.err);
                cmp($sformatf("u%0d fail_vec", idx), int'(fv), int'(e.fv));
                cmp($sformatf("u%0d done cycle", idx), cyc, e.cyc);
            end
        end
    endtask

    task automatic push(input int idx, input logic p, input int err, input logic [6:0] fv,
                        input int done_cyc);
        exp_t e;
        e.pass = p; e.err = err; e.fv = fv; e.cyc = done_cyc;
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Queue the expected result, then pulse start for one sampling edge
    task automatic launch(input int idx, input logic p, input int err, input logic [6:0] fv,
                          input int lat);
        push(idx, p, err, fv, cyc + 1 + lat);
        case (idx)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        tick();
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q0.size() + q1.size() + q2.size() == 0) break;
            tick();
        end
        cmp("pending results after wait", q0.size() + q1.size() + q2.size(), 0);
    endtask

    task automatic chk_reset0(input string tag);
        cmp({tag, " a"}, int'(a0), 0);
        cmp({tag, " b"}, int'(b0), 0);
        cmp({tag, " busy"}, int'(busy0), 0);
        cmp({tag, " done"}, int'(done0), 0);
        cmp({tag, " pass"}, int'(pass0), 0);
        cmp({tag, " fail_vec"}, int'(fv0), 0);
        cmp({tag, " err_count"}, int'(err0), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon(0, done0, pass0, int'(err0), fv0);
                mon(1, done1, pass1, int'(err1), fv1);
                mon(2, done2, pass2, int'(err2), fv2);
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        repeat (3) tick();
        chk_reset0("reset u0");
        cmp("reset u1 busy/done/pass", int'({busy1, done1, pass1}), 0);
        cmp("reset u2 a/b/err/fv", int'({a2, b2, err2, fv2}), 0);
        rst = 1'b0;
        tick();

        // 1: correct gates, a/b walk 00,01,10,11 two cycles each
        launch(0, 1'b1, 0, 7'h00, 9);
        for (int j = 0; j < 8; j++) begin
            cmp($sformatf("u0 ab step %0d", j), int'({a0, b0}), j >> 1);
            cmp($sformatf("u0 busy step %0d", j), int'(busy0), 1);
            tick();
        end
        drain(20);
        cmp("u0 idle a/b", int'({a0, b0}), 0);
        cmp("u0 pass held", int'(pass0), 1);

        // 2: xor stuck at 0 misses vectors 01 and 10
        mode0 = 1;
        launch(0, 1'b0, 2, 7'b0100000, 9);
        drain(20);
        mode0 = 0;

        // 3: and wired from nand, two passes
        launch(1, 1'b0, 8, 7'b0000001, 17);
        drain(30);

        // 4: all outputs inverted, count saturates at 3
        launch(2, 1'b0, 3, 7'h7F, 9);
        drain(20);

        // 5: start during busy and done is ignored; held start relaunches from IDLE
        mode0 = 1;
        push(0, 1'b0, 2, 7'b0100000, cyc + 1 + 9);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (2) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (5) tick();
        push(0, 1'b1, 0, 7'h00, cyc + 11);
        mode0 = 0;
        start0 = 1'b1;
        repeat (2) tick();
        start0 = 1'b0;
        cmp("u0 relaunch err cleared", int'(err0), 0);
        cmp("u0 relaunch busy", int'(busy0), 1);
        drain(40);

        // 6: reset mid-sweep aborts, clears counts and the earlier pass
        mode0 = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        cmp("u0 err before abort", int'(err0), 1);
        rst = 1'b1;
        tick();
        chk_reset0("abort u0");
        rst = 1'b0;
        repeat (12) tick();
        mode0 = 0;
        launch(0, 1'b1, 0, 7'h00, 9);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
